id_ex_stage: RTL and testbench

//  Decode stage with its ID/EX pipeline register. The main/ALU decoder turns instr_d into control signals.
//  It drives imm_src_d to the sign extender: 000 I, 001 S, 010 B, 011 J, 100 U.
//  It registers the control word, rs1/rs2 data, imm_ext_d, PCs and register addresses into the EX stage.

---
 rtl/riscv_pkg.sv | 50 +++++
 rtl/main_decoder.sv | 104 ++++++++++
 rtl/id_ex_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode, immediate-select, ALU and result-select codes
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src_b;
        logic       alu_src_a;
        logic       illegal;
        logic [1:0] result_src;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - combinational main/ALU decoder: opcode fields to control word and imm_src
module main_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    input  logic       rd_zero_i,
    input  logic       valid_i,
    output ctrl_t      ctrl_o,
    output logic [2:0] imm_src_o,
    output logic       bubble_o
);

    logic [3:0] alu_fn;
    logic       bad;
    ctrl_t      ctrl;

    // funct3 selects the ALU op for R and I-ALU; funct7[5] picks SUB only for R, SRA for both
    always_comb begin
        alu_fn = ALU_ADD;
        case (funct3_i)
            3'b000:  alu_fn = (funct7_5_i && (opcode_i == OP_R)) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = funct7_5_i ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: alu_fn = ALU_ADD;
        endcase
    end

    // opcode decode; unknown opcodes and empty slots collapse to a bubble
    always_comb begin
        ctrl      = CTRL_BUBBLE;
        imm_src_o = IMM_I;
        bad       = 1'b0;
        case (opcode_i)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_fn;
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = alu_fn;
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                imm_src_o      = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                imm_src_o     = IMM_B;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src_o       = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            OP_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_IMM;
                imm_src_o       = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_src_a = 1'b1;
                imm_src_o      = IMM_U;
            end
            default: bad = 1'b1;
        endcase
        // x0 writes are dropped here so hazard logic never forwards or stalls on x0
        if (rd_zero_i) begin
            ctrl.reg_write = 1'b0;
        end
        bubble_o = !valid_i || bad;
        if (bubble_o) begin
            ctrl         = CTRL_BUBBLE;
            ctrl.illegal = valid_i & bad;
        end
        ctrl_o = ctrl;
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode stage with ID/EX pipeline register, stall and flush control
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_ext_d,
    output logic [2:0]      imm_src_d,
    output logic [RA_W-1:0] rs1_d,
    output logic [RA_W-1:0] rs2_d,
    output logic            reg_write_e,
    output logic            mem_write_e,
    output logic            branch_e,
    output logic            jump_e,
    output logic            alu_src_b_e,
    output logic            alu_src_a_e,
    output logic            illegal_e,
    output logic [1:0]      result_src_e,
    output logic [3:0]      alu_ctrl_e,
    output logic [2:0]      funct3_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [RA_W-1:0] rs1_e,
    output logic [RA_W-1:0] rs2_e,
    output logic [RA_W-1:0] rd_e
);

    typedef struct packed {
        ctrl_t           ctrl;
        logic [2:0]      funct3;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
    } ex_t;

    ctrl_t           ctrl_d;
    logic            bubble_d;
    logic [RA_W-1:0] rd_d;
    ex_t             cap_d;
    ex_t             e_d;
    ex_t             e_q;
    logic            unused_instr_bits;

    assign rs1_d = instr_d[15 +: RA_W];
    assign rs2_d = instr_d[20 +: RA_W];
    assign rd_d  = instr_d[7 +: RA_W];

    assign unused_instr_bits = ^{instr_d[31], instr_d[29:25]};

    main_decoder u_main_decoder (
        .opcode_i   (instr_d[6:0]),
        .funct3_i   (instr_d[14:12]),
        .funct7_5_i (instr_d[30]),
        .rd_zero_i  (rd_d == '0),
        .valid_i    (valid_d),
        .ctrl_o     (ctrl_d),
        .imm_src_o  (imm_src_d),
        .bubble_o   (bubble_d)
    );

    // word offered to EX: full capture, or an all-zero bubble that keeps only the illegal flag
    always_comb begin
        cap_d      = '0;
        cap_d.ctrl = ctrl_d;
        if (!bubble_d) begin
            cap_d.funct3 = instr_d[14:12];
            cap_d.rd1    = rd1_d;
            cap_d.rd2    = rd2_d;
            cap_d.imm    = imm_ext_d;
            cap_d.pc     = pc_d;
            cap_d.pc4    = pc_plus4_d;
            cap_d.rs1    = rs1_d;
            cap_d.rs2    = rs2_d;
            cap_d.rd     = rd_d;
        end
    end

    // flush beats stall: a squashed instruction must never linger in EX
    always_comb begin
        e_d = e_q;
        if (flush_e) begin
            e_d = '0;
        end else if (!stall_e) begin
            e_d = cap_d;
        end
    end

    // ID/EX register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign reg_write_e  = e_q.ctrl.reg_write;
    assign mem_write_e  = e_q.ctrl.mem_write;
    assign branch_e     = e_q.ctrl.branch;
    assign jump_e       = e_q.ctrl.jump;
    assign alu_src_b_e  = e_q.ctrl.alu_src_b;
    assign alu_src_a_e  = e_q.ctrl.alu_src_a;
    assign illegal_e    = e_q.ctrl.illegal;
    assign result_src_e = e_q.ctrl.result_src;
    assign alu_ctrl_e   = e_q.ctrl.alu_ctrl;
    assign funct3_e     = e_q.funct3;
    assign rd1_e        = e_q.rd1;
    assign rd2_e        = e_q.rd2;
    assign imm_ext_e    = e_q.imm;
    assign pc_e         = e_q.pc;
    assign pc_plus4_e   = e_q.pc4;
    assign rs1_e        = e_q.rs1;
    assign rs2_e        = e_q.rs2;
    assign rd_e         = e_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage: vector table, corner sequences, random vs model
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall_e, flush_e, valid_d;
    logic [31:0] instr_d, pc_d, pc_plus4_d, rd1_d, rd2_d, imm_ext_d;
    logic [2:0]  imm_src_d;
    logic [4:0]  rs1_d, rs2_d;
    logic        reg_write_e, mem_write_e, branch_e, jump_e, alu_src_b_e, alu_src_a_e, illegal_e;
    logic [1:0]  result_src_e;
    logic [3:0]  alu_ctrl_e;
    logic [2:0]  funct3_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .imm_ext_d(imm_ext_d), .imm_src_d(imm_src_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e),
        .alu_src_b_e(alu_src_b_e), .alu_src_a_e(alu_src_a_e), .illegal_e(illegal_e),
        .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e), .funct3_e(funct3_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
    );

    // rw mw br jp srcb srca ill | result_src | alu_ctrl
    typedef struct packed {
        logic rw, mw, br, jp, sb, sa, il;
        logic [1:0] rs;
        logic [3:0] alu;
    } ctl_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } dat_t;

    typedef struct {
        logic [31:0] ins;
        logic        v;
        logic [2:0]  isrc;
        ctl_t        c;
        logic [4:0]  rd;
        bit          chk;
    } vec_t;

    typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_BAD} kind_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    ctl_t exp_c;
    dat_t exp_d;
    bit   exp_dc;
    vec_t tbl[14];

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_BEQ = 32'h00208063;
    localparam logic [31:0] I_LW  = 32'h0040A283;
    localparam logic [31:0] I_LUI = 32'h000122B7;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ctl_t act_ctl();
        return {reg_write_e, mem_write_e, branch_e, jump_e, alu_src_b_e, alu_src_a_e, illegal_e,
                result_src_e, alu_ctrl_e};
    endfunction

    function automatic dat_t act_dat();
        return {funct3_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e};
    endfunction

    // reference decode: classify the instruction, then read properties off per-kind rules
    function automatic void model(input logic [31:0] ins, input logic v, output ctl_t c,
                                  output dat_t d, output bit dcare, output logic [2:0] isrc);
        kind_t      k;
        logic [3:0] ops[8];
        logic [2:0] f3;
        ops = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        f3  = ins[14:12];
        case (ins[6:0])
            7'h33:   k = K_R;
            7'h13:   k = K_I;
            7'h03:   k = K_LD;
            7'h23:   k = K_ST;
            7'h63:   k = K_BR;
            7'h6F:   k = K_JAL;
            7'h67:   k = K_JALR;
            7'h37:   k = K_LUI;
            7'h17:   k = K_AUIPC;
            default: k = K_BAD;
        endcase
        isrc  = (k == K_ST) ? 3'd1 : (k == K_BR) ? 3'd2 : (k == K_JAL) ? 3'd3 :
                (k == K_LUI || k == K_AUIPC) ? 3'd4 : 3'd0;
        c     = '0;
        d     = '0;
        dcare = 1'b1;
        if (!v || k == K_BAD) begin
            c.il  = v && (k == K_BAD);
            dcare = 1'b0;
            return;
        end
        c.rw = (k != K_ST) && (k != K_BR) && (ins[11:7] != 5'd0);
        c.mw = (k == K_ST);
        c.br = (k == K_BR);
        c.jp = (k == K_JAL) || (k == K_JALR);
        c.sb = !((k == K_R) || (k == K_BR));
        c.sa = (k == K_AUIPC);
        c.rs = (k == K_LD) ? 2'd1 : c.jp ? 2'd2 : (k == K_LUI) ? 2'd3 : 2'd0;
        if (k == K_R || k == K_I) begin
            c.alu = ops[f3];
            if (f3 == 3'd5 && ins[30]) c.alu = 4'd9;
            if (k == K_R && f3 == 3'd0 && ins[30]) c.alu = 4'd1;
        end else if (k == K_BR) begin
            c.alu = 4'd1;
        end
        d = {f3, rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d, ins[19:15], ins[24:20], ins[11:7]};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
        instr_d    = ins;
        valid_d    = v;
        stall_e    = st;
        flush_e    = fl;
        pc_d       = $urandom & 32'hFFFF_FFFC;
        pc_plus4_d = pc_d + 32'd4;
        rd1_d      = $urandom;
        rd2_d      = $urandom;
        imm_ext_d  = $urandom;
    endtask

    // advance one edge, keeping the reference ID/EX contents in step
    task automatic tick();
        ctl_t       c;
        dat_t       d;
        bit         dc;
        logic [2:0] is;
        model(instr_d, valid_d, c, d, dc, is);
        if (flush_e) begin
            exp_c  = '0;
            exp_d  = '0;
            exp_dc = 1'b1;
        end else if (!stall_e) begin
            exp_c  = c;
            exp_d  = d;
            exp_dc = dc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " ctrl"}, 200'(act_ctl()), 200'(exp_c));
        if (exp_dc) check({tag, " data"}, 200'(act_dat()), 200'(exp_d));
    endtask

    initial begin
        logic [6:0]  op_list[10];
        logic [31:0] ins;
        ctl_t        mc;
        dat_t        md;
        bit          mdc;
        logic [2:0]  mis;

        op_list = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

        tbl[0]  = '{I_ADD,        1'b1, 3'b000, 13'b1000000_00_0000, 5'd3, 1'b1};
        tbl[1]  = '{32'h0020A423, 1'b1, 3'b001, 13'b0100100_00_0000, 5'd8, 1'b1};
        tbl[2]  = '{32'h407302B3, 1'b1, 3'b000, 13'b1000000_00_0001, 5'd5, 1'b1};
        tbl[3]  = '{32'h4030D093, 1'b1, 3'b000, 13'b1000100_00_1001, 5'd1, 1'b1};
        tbl[4]  = '{32'hC0000093, 1'b1, 3'b000, 13'b1000100_00_0000, 5'd1, 1'b1};
        tbl[5]  = '{32'h000000EF, 1'b1, 3'b011, 13'b1001100_10_0000, 5'd1, 1'b1};
        tbl[6]  = '{I_LUI,        1'b1, 3'b100, 13'b1000100_11_0000, 5'd5, 1'b1};
        tbl[7]  = '{32'h00001217, 1'b1, 3'b100, 13'b1000110_00_0000, 5'd4, 1'b1};
        tbl[8]  = '{I_BEQ,        1'b1, 3'b010, 13'b0010000_00_0001, 5'd0, 1'b1};
        tbl[9]  = '{32'h0000007F, 1'b1, 3'b000, 13'b0000001_00_0000, 5'd0, 1'b0};
        tbl[10] = '{32'h00100013, 1'b1, 3'b000, 13'b0000100_00_0000, 5'd0, 1'b1};
        tbl[11] = '{I_ADD,        1'b0, 3'b000, 13'b0000000_00_0000, 5'd0, 1'b0};
        tbl[12] = '{32'h000100E7, 1'b1, 3'b000, 13'b1001100_10_0000, 5'd1, 1'b1};
        tbl[13] = '{I_LW,         1'b1, 3'b000, 13'b1000100_01_0000, 5'd5, 1'b1};

        rst_n = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        exp_c  = '0;
        exp_d  = '0;
        exp_dc = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset ctrl", 200'(act_ctl()), 200'(0));
        check("reset data", 200'(act_dat()), 200'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].ins, tbl[i].v, 1'b0, 1'b0);
            #1;
            check($sformatf("tbl%0d imm_src_d", i), 200'(imm_src_d), 200'(tbl[i].isrc));
            tick();
            check($sformatf("tbl%0d ctrl", i), 200'(act_ctl()), 200'(tbl[i].c));
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d rd_e", i), 200'(rd_e), 200'(tbl[i].rd));
                check($sformatf("tbl%0d imm_ext_e", i), 200'(imm_ext_e), 200'(imm_ext_d));
            end
        end

        drive(I_ADD, 1'b1, 1'b0, 1'b0);
        tick();
        drive(I_BEQ, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d ctrl", i), 200'(act_ctl()), 200'(13'b1000000_00_0000));
            check($sformatf("stall%0d rd_e", i), 200'(rd_e), 200'(5'd3));
        end
        stall_e = 1'b0;
        tick();
        check("stall release ctrl", 200'(act_ctl()), 200'(13'b0010000_00_0001));

        drive(I_ADD, 1'b1, 1'b0, 1'b0);
        tick();
        drive(I_LW, 1'b1, 1'b1, 1'b1);
        tick();
        check("flush+stall ctrl", 200'(act_ctl()), 200'(0));
        check("flush+stall data", 200'(act_dat()), 200'(0));

        drive(I_LUI, 1'b1, 1'b0, 1'b0);
        tick();
        check("lui result_src", 200'(result_src_e), 200'(2'b11));
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset ctrl", 200'(act_ctl()), 200'(0));
        check("async reset data", 200'(act_dat()), 200'(0));
        exp_c  = '0;
        exp_d  = '0;
        exp_dc = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        drive(I_ADD, 1'b1, 1'b0, 1'b0);
        tick();
        check("post-reset capture ctrl", 200'(act_ctl()), 200'(13'b1000000_00_0000));

        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[6:0] = op_list[$urandom_range(9, 0)];
            if ($urandom_range(15, 0) == 0) ins = $urandom;
            if ($urandom_range(7, 0) == 0) ins[11:7] = 5'd0;
            drive(ins, $urandom_range(9, 0) != 0, $urandom_range(4, 0) == 0, $urandom_range(9, 0) == 0);
            #1;
            model(instr_d, valid_d, mc, md, mdc, mis);
            check($sformatf("rnd%0d imm_src_d", n), 200'(imm_src_d), 200'(mis));
            check($sformatf("rnd%0d rs_d", n), 200'({rs1_d, rs2_d}), 200'({ins[19:15], ins[24:20]}));
            tick();
            check_model($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
